// File: rtl/mapper_mmc1_if.sv
// Bus bundle between the CPU/PPU side and the MMC1 mapper: CPU write port,
// PPU address, and the translated PRG/CHR/VRAM outputs.
interface mapper_mmc1_if #(
  parameter int PRG_AW = 17,
  parameter int CHR_AW = 17
);
  logic              ce;
  logic [15:0]       cpu_a;
  logic [7:0]        cpu_d;
  logic              cpu_w;
  logic [13:0]       chra;
  logic [PRG_AW-1:0] prg_address;
  logic [CHR_AW-1:0] chr_address;
  logic              ciram_a10;
  logic              prg_ram_en;

  modport master (
    output ce, cpu_a, cpu_d, cpu_w, chra,
    input  prg_address, chr_address, ciram_a10, prg_ram_en
  );

  modport slave (
    input  ce, cpu_a, cpu_d, cpu_w, chra,
    output prg_address, chr_address, ciram_a10, prg_ram_en
  );
endinterface

// File: rtl/mapper_mmc1.sv
// MMC1 (SxROM) mapper: 5-bit serial register port at $8000-$FFFF and the
// combinational PRG/CHR bank translation plus nametable mirroring.
module mapper_mmc1 #(
  parameter int PRG_AW = 17,
  parameter int CHR_AW = 17
) (
  input  logic          clock,
  input  logic          reset,
  mapper_mmc1_if.slave  bus
);
  localparam logic [3:0] PRG_MASK = 4'((1 << (PRG_AW - 14)) - 1);

  logic [4:0] sr_reg;
  logic [2:0] cnt_reg;
  logic       wr_prev_reg;
  logic [4:0] ctrl_reg;
  logic [4:0] chr0_reg;
  logic [4:0] chr1_reg;
  logic [4:0] prg_reg;

  logic       wr_hit;
  logic       wr_accept;
  logic [4:0] shift_next;

  assign wr_hit     = bus.cpu_w & bus.cpu_a[15];
  // Only the first cycle of a run of back-to-back writes is taken (RMW double writes).
  assign wr_accept  = bus.ce & wr_hit & ~wr_prev_reg;
  assign shift_next = {bus.cpu_d[0], sr_reg[4:1]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr_reg      <= 5'h00;
      cnt_reg     <= 3'd0;
      wr_prev_reg <= 1'b0;
      ctrl_reg    <= 5'h0C;
      chr0_reg    <= 5'h00;
      chr1_reg    <= 5'h00;
      prg_reg     <= 5'h00;
    end else if (bus.ce) begin
      wr_prev_reg <= wr_hit;
      if (wr_accept) begin
        if (bus.cpu_d[7]) begin
          sr_reg   <= 5'h00;
          cnt_reg  <= 3'd0;
          ctrl_reg <= ctrl_reg | 5'h0C;
        end else if (cnt_reg != 3'd4) begin
          sr_reg  <= shift_next;
          cnt_reg <= cnt_reg + 3'd1;
        end else begin
          case (bus.cpu_a[14:13])
            2'd0:    ctrl_reg <= shift_next;
            2'd1:    chr0_reg <= shift_next;
            2'd2:    chr1_reg <= shift_next;
            default: prg_reg  <= shift_next;
          endcase
          sr_reg  <= 5'h00;
          cnt_reg <= 3'd0;
        end
      end
    end
  end

  logic [3:0] prg_b;
  logic [3:0] prg_bank;
  logic [4:0] chr_bank;
  logic       ciram_next;

  always_comb begin
    prg_b = prg_reg[3:0] & PRG_MASK;
    case (ctrl_reg[3:2])
      2'd0, 2'd1: prg_bank = {prg_b[3:1], bus.cpu_a[14]};
      2'd2:       prg_bank = bus.cpu_a[14] ? prg_b : 4'd0;
      default:    prg_bank = bus.cpu_a[14] ? PRG_MASK : prg_b;
    endcase
  end

  always_comb begin
    if (ctrl_reg[4])
      chr_bank = bus.chra[12] ? chr1_reg : chr0_reg;
    else
      chr_bank = {chr0_reg[4:1], bus.chra[12]};
  end

  always_comb begin
    case (ctrl_reg[1:0])
      2'd0:    ciram_next = 1'b0;
      2'd1:    ciram_next = 1'b1;
      2'd2:    ciram_next = bus.chra[10];
      default: ciram_next = bus.chra[11];
    endcase
  end

  assign bus.prg_address = PRG_AW'({prg_bank, bus.cpu_a[13:0]});
  assign bus.chr_address = CHR_AW'({chr_bank, bus.chra[11:0]});
  assign bus.ciram_a10   = ciram_next;
  assign bus.prg_ram_en  = ~prg_reg[4];

  logic unused_bits;
  assign unused_bits = ^{bus.cpu_d[6:1], bus.chra[13]};
endmodule

// File: tb/tb_mapper_mmc1.sv
// Directed bench for mapper_mmc1: serial register loads, bank translation,
// mirroring, reset abort and write qualification.
module tb_mapper_mmc1;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mapper_mmc1_if #(.PRG_AW(17), .CHR_AW(17)) bus ();

  mapper_mmc1 #(.PRG_AW(17), .CHR_AW(17)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.cpu_a = a;
    bus.cpu_d = d;
    bus.cpu_w = 1'b1;
    @(negedge clk);
    bus.cpu_w = 1'b0;
    $display("write a=%h d=%h", a, d);
  endtask

  task automatic wr5(input logic [15:0] a, input logic [4:0] v);
    for (int i = 0; i < 5; i++) wr(a, {7'd0, v[i]});
  endtask

  task automatic prg_chk(input string tag, input logic [15:0] a, input logic [16:0] exp);
    bus.cpu_a = a;
    #1;
    chk(tag, 32'(bus.prg_address), 32'(exp));
  endtask

  task automatic chr_chk(input string tag, input logic [13:0] a, input logic [16:0] exp);
    bus.chra = a;
    #1;
    chk(tag, 32'(bus.chr_address), 32'(exp));
  endtask

  task automatic mir_chk(input string tag, input logic [13:0] a, input logic exp);
    bus.chra = a;
    #1;
    chk(tag, 32'(bus.ciram_a10), 32'(exp));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.ce    = 1'b1;
    bus.cpu_a = 16'h0000;
    bus.cpu_d = 8'h00;
    bus.cpu_w = 1'b0;
    bus.chra  = 14'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state: mode 3, last bank fixed high, work RAM on, one-screen A.
    chk("rst_ram_en", 32'(bus.prg_ram_en), 32'd1);
    mir_chk("rst_ciram", 14'h2400, 1'b0);
    prg_chk("rst_prg_c123", 16'hC123, 17'h1C123);
    prg_chk("rst_prg_8123", 16'h8123, 17'h00123);
    chr_chk("rst_chr_1abc", 14'h1ABC, 17'h01ABC);

    // prg = 5 through $E000
    wr5(16'hE000, 5'd5);
    prg_chk("prg5_8000", 16'h8000, 17'h14000);
    prg_chk("prg5_c000", 16'hC000, 17'h1C000);
    chk("prg5_ram_en", 32'(bus.prg_ram_en), 32'd1);

    // chr1 = 3, then ctrl = 0x12 (CHR 4K, vertical, 32K PRG)
    wr5(16'hC000, 5'd3);
    wr5(16'h8000, 5'h12);
    chr_chk("c4k_1abc", 14'h1ABC, 17'h03ABC);
    chr_chk("c4k_0abc", 14'h0ABC, 17'h00ABC);
    mir_chk("vert_2400", 14'h2400, 1'b1);
    mir_chk("vert_2800", 14'h2800, 1'b0);
    prg_chk("p32k_c000", 16'hC000, 17'h14000);
    prg_chk("p32k_8000", 16'h8000, 17'h10000);

    // Adjacent-cycle writes shift only once
    @(negedge clk);
    bus.cpu_a = 16'h8000;
    bus.cpu_d = 8'h01;
    bus.cpu_w = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.cpu_w = 1'b0;
    $display("write a=8000 d=01 (two adjacent cycles)");
    chk("adj_cnt", 32'(dut.cnt_reg), 32'd1);
    chk("adj_sr", 32'(dut.sr_reg), 32'h10);

    // Two more bits, then a reset-bit write
    wr(16'h8000, 8'h00);
    wr(16'h8000, 8'h00);
    chk("three_cnt", 32'(dut.cnt_reg), 32'd3);
    wr(16'h8000, 8'h80);
    chk("rb_cnt", 32'(dut.cnt_reg), 32'd0);
    chk("rb_sr", 32'(dut.sr_reg), 32'd0);
    chk("rb_ctrl", 32'(dut.ctrl_reg), 32'h1E);
    prg_chk("rb_prg_8000", 16'h8000, 17'h14000);
    prg_chk("rb_prg_c000", 16'hC000, 17'h1C000);
    chr_chk("rb_chr_1abc", 14'h1ABC, 17'h03ABC);
    mir_chk("rb_mirror", 14'h2400, 1'b1);

    // Reset in the middle of a sequence discards the partial shift
    wr(16'hA000, 8'h01);
    wr(16'hA000, 8'h01);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_cnt", 32'(dut.cnt_reg), 32'd0);
    chk("abort_ctrl", 32'(dut.ctrl_reg), 32'h0C);
    @(negedge clk);
    rst = 1'b0;
    wr5(16'hA000, 5'd3);
    chk("fresh_chr0", 32'(dut.chr0_reg), 32'd3);
    chr_chk("c8k_0abc", 14'h0ABC, 17'h02ABC);
    chr_chk("c8k_1abc", 14'h1ABC, 17'h03ABC);

    // prg[4] disables work RAM
    wr5(16'hE000, 5'h10);
    chk("ramdis", 32'(bus.prg_ram_en), 32'd0);
    prg_chk("ramdis_8123", 16'h8123, 17'h00123);
    prg_chk("ramdis_c123", 16'hC123, 17'h1C123);

    // Writes below $8000 and writes without ce are ignored
    wr(16'h6000, 8'h01);
    chk("low_write_cnt", 32'(dut.cnt_reg), 32'd0);
    @(negedge clk);
    bus.ce    = 1'b0;
    bus.cpu_a = 16'h8000;
    bus.cpu_d = 8'h01;
    bus.cpu_w = 1'b1;
    @(negedge clk);
    bus.cpu_w = 1'b0;
    bus.ce    = 1'b1;
    $display("write a=8000 d=01 (ce low)");
    chk("no_ce_cnt", 32'(dut.cnt_reg), 32'd0);
    chk("no_ce_sr", 32'(dut.sr_reg), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
